// File: rtl/note_scheduler.sv
// Note-table controller: bus-written shadow table, frame-synchronous commit/scroll
// into the active table, and a registered per-pixel note-head hit test.

module note_hit #(
  parameter int NOTE_W = 8,
  parameter int NOTE_H = 8,
  parameter int Y0     = 100,
  parameter int PSTEP  = 4
) (
  input  logic [15:0] i_slot,
  input  logic [9:0]  i_x,
  input  logic [9:0]  i_y,
  output logic        o_hit
);
  logic [10:0] w_x, w_ytop, w_px, w_py;

  // 11-bit compare so x+NOTE_W / ytop+NOTE_H never wrap
  assign w_x    = {1'b0, i_slot[9:0]};
  assign w_ytop = 11'(Y0) + ({6'd0, i_slot[14:10]} * 11'(PSTEP));
  assign w_px   = {1'b0, i_x};
  assign w_py   = {1'b0, i_y};

  assign o_hit = i_slot[15]
              && (w_px >= w_x)    && (w_px < w_x + 11'(NOTE_W))
              && (w_py >= w_ytop) && (w_py < w_ytop + 11'(NOTE_H));
endmodule

module note_scheduler #(
  parameter int NOTES  = 8,
  parameter int NOTE_W = 8,
  parameter int NOTE_H = 8,
  parameter int Y0     = 100,
  parameter int PSTEP  = 4,
  parameter int SCROLL = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     wr_en,
  input  logic [$clog2(NOTES)-1:0] wr_addr,
  input  logic [15:0]              wr_data,
  input  logic                     commit,
  input  logic                     frame_tick,
  input  logic [9:0]               DrawX,
  input  logic [9:0]               DrawY,
  output logic                     draw_note,
  output logic [$clog2(NOTES)-1:0] note_idx,
  output logic                     busy,
  output logic                     commit_done
);
  localparam int IW = $clog2(NOTES);
  localparam logic [IW-1:0] LAST = IW'(NOTES - 1);

  typedef enum logic [1:0] {IDLE, COPY, SCROLLING} state_t;

  state_t                 r_state;
  logic [IW-1:0]          r_i;
  logic                   r_pending;
  logic [NOTES-1:0][15:0] r_shadow;
  logic [NOTES-1:0][15:0] r_active;
  logic                   r_draw;
  logic [IW-1:0]          r_idx;

  logic [NOTES-1:0]       w_hit;
  logic                   w_any;
  logic [IW-1:0]          w_idx;
  logic                   w_start;
  logic                   w_do_copy;
  logic                   w_show;

  // Shadow table: bus writes land in every state
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_shadow <= '0;
    end else if (wr_en) begin
      r_shadow[wr_addr] <= wr_data;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NOTES; g++) begin : g_hit
      note_hit #(.NOTE_W(NOTE_W), .NOTE_H(NOTE_H), .Y0(Y0), .PSTEP(PSTEP)) u_hit (
        .i_slot (r_active[g]),
        .i_x    (DrawX),
        .i_y    (DrawY),
        .o_hit  (w_hit[g])
      );
    end
  endgenerate

  // Lowest hitting slot wins
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int k = NOTES - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_any = 1'b1;
        w_idx = IW'(k);
      end
    end
  end

  assign w_start   = (r_state == IDLE) && frame_tick;
  assign w_do_copy = r_pending || commit;
  // Pixel result is only published when the table is stable for the next cycle
  assign w_show    = (r_state == IDLE) && !frame_tick;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_pending <= 1'b0;
      r_active  <= '0;
      r_draw    <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_draw <= w_show && w_any;
      r_idx  <= (w_show && w_any) ? w_idx : '0;

      if (w_start && w_do_copy) r_pending <= 1'b0;
      else if (commit)          r_pending <= 1'b1;

      case (r_state)
        IDLE: begin
          if (frame_tick) begin
            r_state <= w_do_copy ? COPY : SCROLLING;
            r_i     <= '0;
          end
        end
        COPY: begin
          r_active[r_i] <= r_shadow[r_i];
          r_i           <= r_i + 1'b1;
          if (r_i == LAST) r_state <= IDLE;
        end
        SCROLLING: begin
          if (r_active[r_i][15]) begin
            if (r_active[r_i][9:0] < 10'(SCROLL)) r_active[r_i][15] <= 1'b0;
            else r_active[r_i][9:0] <= r_active[r_i][9:0] - 10'(SCROLL);
          end
          r_i <= r_i + 1'b1;
          if (r_i == LAST) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign commit_done = (r_state == COPY) && (r_i == LAST);
  assign draw_note   = r_draw;
  assign note_idx    = r_idx;
endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: commit/scroll sequencing, hit-test geometry,
// priority, write/copy collision, busy-tick rejection and async reset.

module tb_note_scheduler;
  localparam int NOTES = 8;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [15:0] wr_data;
  logic       commit;
  logic       frame_tick;
  logic [9:0] DrawX, DrawY;
  logic       draw_note;
  logic [2:0] note_idx;
  logic       busy;
  logic       commit_done;

  int tests = 0;
  int fails = 0;

  note_scheduler #(.NOTES(NOTES)) dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .frame_tick(frame_tick), .DrawX(DrawX), .DrawY(DrawY),
    .draw_note(draw_note), .note_idx(note_idx), .busy(busy), .commit_done(commit_done)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Full update frame: tick, then NOTES busy cycles, land back in IDLE
  task automatic frame(input logic with_commit);
    if (with_commit) begin
      commit = 1'b1; step(); commit = 1'b0;
    end
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    repeat (NOTES) step();
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic ed, input logic [2:0] ei);
    DrawX = 10'(x); DrawY = 10'(y);
    step();
    check({tag, ".draw"}, 16'(draw_note), 16'(ed));
    check({tag, ".idx"}, 16'(note_idx), 16'(ei));
  endtask

  initial begin
    Reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    commit = 1'b0; frame_tick = 1'b0; DrawX = '0; DrawY = '0;
    repeat (3) step();
    check("rst.draw", 16'(draw_note), 16'd0);
    check("rst.idx", 16'(note_idx), 16'd0);
    check("rst.busy", 16'(busy), 16'd0);
    check("rst.done", 16'(commit_done), 16'd0);
    Reset = 1'b1;
    step();

    // slot 0 = {valid, pitch 2, x 100}: ytop = 100 + 2*4 = 108
    wr(3'd0, 16'h8864);
    commit = 1'b1; step(); commit = 1'b0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    for (int c = 1; c <= NOTES; c++) begin
      check($sformatf("copy.busy%0d", c), 16'(busy), 16'd1);
      check($sformatf("copy.done%0d", c), 16'(commit_done), (c == NOTES) ? 16'd1 : 16'd0);
      step();
    end
    check("copy.busy_end", 16'(busy), 16'd0);
    check("copy.done_end", 16'(commit_done), 16'd0);

    pix("hit0", 100, 108, 1'b1, 3'd0);
    pix("miss_x", 108, 108, 1'b0, 3'd0);
    pix("miss_y", 100, 116, 1'b0, 3'd0);
    pix("corner", 107, 115, 1'b1, 3'd0);

    // Scroll frame with a second frame_tick while busy: ignored, not queued
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step(); step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    repeat (NOTES - 3) step();
    check("busytick.busy", 16'(busy), 16'd0);
    step();
    check("busytick.noqueue", 16'(busy), 16'd0);
    frame(1'b0);
    frame(1'b0);
    pix("scroll94", 94, 108, 1'b1, 3'd0);
    pix("scroll93", 93, 108, 1'b0, 3'd0);

    // slot 3 x=1 pitch 0; slots 2,5 x=196/198 pitch 4 (ytop 116)
    wr(3'd3, 16'h8001);
    wr(3'd2, 16'h90C4);
    wr(3'd5, 16'h90C6);
    frame(1'b1);
    pix("overlap", 200, 120, 1'b1, 3'd2);
    pix("slot3", 1, 100, 1'b1, 3'd3);
    pix("slot0_back", 100, 108, 1'b1, 3'd0);
    frame(1'b0);
    pix("slot3_gone", 1, 100, 1'b0, 3'd0);
    pix("overlap_scr", 200, 120, 1'b1, 3'd2);
    pix("slot5_only", 203, 120, 1'b1, 3'd5);
    frame(1'b0);
    pix("slot3_still", 0, 100, 1'b0, 3'd0);

    // Slot 4: A = x 300 pitch 6 (ytop 124), B = x 400 written while COPY handles slot 4
    wr(3'd4, 16'h992C);
    frame(1'b1);
    commit = 1'b1; step(); commit = 1'b0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    repeat (4) step();
    wr(3'd4, 16'h9990);
    repeat (NOTES - 5) step();
    check("coll.idle", 16'(busy), 16'd0);
    pix("coll.old", 300, 124, 1'b1, 3'd4);
    pix("coll.notnew", 400, 124, 1'b0, 3'd0);
    frame(1'b1);
    pix("coll.new", 400, 124, 1'b1, 3'd4);
    pix("coll.oldgone", 300, 124, 1'b0, 3'd0);

    // Reset mid-SCROLL
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step(); step();
    Reset = 1'b0;
    #1;
    check("mid.busy", 16'(busy), 16'd0);
    check("mid.done", 16'(commit_done), 16'd0);
    check("mid.draw", 16'(draw_note), 16'd0);
    check("mid.idx", 16'(note_idx), 16'd0);
    step();
    Reset = 1'b1;
    pix("post.s4", 400, 124, 1'b0, 3'd0);
    pix("post.s2", 200, 120, 1'b0, 3'd0);
    pix("post.s0", 100, 108, 1'b0, 3'd0);
    frame(1'b1);
    pix("post.commit_s4", 400, 124, 1'b0, 3'd0);
    pix("post.commit_s0", 100, 108, 1'b0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
